// File: rtl/rk_window_pkg.sv
// rk_window_pkg: shared FSM encoding and parameter helpers for the row-window controller
package rk_window_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        START_ROW = 3'd2,
        SUM       = 3'd3,
        CUM       = 3'd4,
        FINISH    = 3'd5,
        DONE      = 3'd6
    } state_t;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit win_ok(input int win, input int cols);
        return (win >= 2) && (win <= cols);
    endfunction
endpackage

// File: rtl/rk_pos_counter.sv
// rk_pos_counter: column/row position counter wrapping at COLS-1 with sync clear
module rk_pos_counter #(
    parameter int COLS = 11,
    parameter int ROWS = 4,
    parameter int CW = 4,
    parameter int RW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          col_last,
    output logic          row_last
);
    assign col_last = col == CW'(COLS - 1);
    assign row_last = row == RW'(ROWS - 1);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            col <= col_last ? '0 : col + 1'b1;
            if (col_last)
                row <= row_last ? '0 : row + 1'b1;
        end
    end
endmodule

// File: rtl/rk_window_controller.sv
// rk_window_controller: row-window FSM with valid/ready handshake, abort and frame re-arm
module rk_window_controller
    import rk_window_pkg::*;
#(
    parameter int COLS = 11,
    parameter int ROWS = 4,
    parameter int WIN = 3,
    parameter int CW = width_of(COLS),
    parameter int RW = width_of(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          done_i,
    input  logic          i_start_ok,
    input  logic          in_valid,
    input  logic          out_ready,
    input  logic          abort,
    output logic          in_ready,
    output logic          start_en,
    output logic          ld_en,
    output logic          sum_en,
    output logic          cum_en,
    output logic          count_en,
    output logic          done_o,
    output logic          progress_done,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o
);
    if (!win_ok(WIN, COLS)) begin : g_bad_win
        $error("rk_window_controller: WIN must satisfy 2 <= WIN <= COLS");
    end

    state_t state, state_nx;
    logic   col_last, row_last, in_win, stall, step, clr;

    assign in_win = (state == SUM) || (state == CUM);
    assign stall  = (state == CUM) && !out_ready;
    assign step   = in_win && in_valid && !stall;
    assign clr    = (abort && state != IDLE) || state == FINISH || state == IDLE;

    rk_pos_counter #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW)) u_pos (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .en       (step),
        .col      (col_o),
        .row      (row_o),
        .col_last (col_last),
        .row_last (row_last)
    );

    always_ff @(posedge clk)
        state <= !rst ? IDLE : state_nx;

    always_comb begin
        state_nx      = state;
        in_ready      = in_win && !stall;
        count_en      = step;
        sum_en        = step && state == SUM;
        cum_en        = step && state == CUM;
        done_o        = state == CUM && in_valid;
        start_en      = state == START;
        ld_en         = state == START_ROW;
        progress_done = state == FINISH;
        case (state)
            IDLE:      state_nx = done_i ? START : IDLE;
            START:     state_nx = i_start_ok ? START_ROW : START;
            START_ROW: state_nx = SUM;
            SUM:       state_nx = (step && col_o == CW'(WIN - 2)) ? CUM : SUM;
            CUM:       state_nx = (step && col_last) ? (row_last ? FINISH : START_ROW) : CUM;
            FINISH:    state_nx = DONE;
            DONE:      state_nx = done_i ? DONE : IDLE;
            default:   state_nx = IDLE;
        endcase
        if (abort && state != IDLE)
            state_nx = IDLE;
    end
endmodule

// File: tb/tb_rk_window_controller.sv
// tb_rk_window_controller: directed scenario tests for rk_window_controller
module tb_rk_window_controller;
    localparam int COLS = 11, ROWS = 4, WIN = 3;

    logic clk = 1'b0, rst = 1'b0, done_i = 1'b0, i_start_ok = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1, abort = 1'b0;
    logic in_ready, start_en, ld_en, sum_en, cum_en, count_en, done_o, progress_done;
    logic [3:0] col_o;
    logic [1:0] row_o;
    int total = 0, bad = 0;
    int n_beat, n_sum, n_cum, n_ld, n_pd, last_cum, pd_cyc;

    always #5 clk = ~clk;

    rk_window_controller #(.COLS(COLS), .ROWS(ROWS), .WIN(WIN)) dut (
        .clk(clk), .rst(rst), .done_i(done_i), .i_start_ok(i_start_ok),
        .in_valid(in_valid), .out_ready(out_ready), .abort(abort),
        .in_ready(in_ready), .start_en(start_en), .ld_en(ld_en), .sum_en(sum_en),
        .cum_en(cum_en), .count_en(count_en), .done_o(done_o),
        .progress_done(progress_done), .col_o(col_o), .row_o(row_o)
    );

    function automatic logic [13:0] all_outs();
        return {in_ready, start_en, ld_en, sum_en, cum_en, count_en, done_o, progress_done, col_o, row_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; done_i = 1'b1; i_start_ok = 1'b0;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (all_outs() !== 14'd0) begin
                bad++;
                $display("FAIL reset_outs got=%h exp=0", all_outs());
            end
            tick();
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (start_en !== 1'b0) begin bad++; $display("FAIL reset_idle start_en got=%b exp=0", start_en); end
        tick();
        @(negedge clk);
        total++;
        if (start_en !== 1'b1) begin bad++; $display("FAIL reset_start start_en got=%b exp=1", start_en); end
        done_i = 1'b0;
        tick();
        @(negedge clk);
        total++;
        if (start_en !== 1'b1) begin bad++; $display("FAIL start_hold start_en got=%b exp=1", start_en); end
        tick();
    endtask

    // Drives one frame; tog toggles in_valid in SUM, bp stalls CUM at row0/col5, ab aborts at row2/col6,
    // hold keeps done_i high through the frame.
    task automatic run_frame(input string nm, input bit tog, input bit bp, input bit ab, input bit hold);
        int  last_ld = 0, sum_row = 0, cum_row = 0, px_row = 0, bp_left = 0, starts = 0;
        bit  in_sum = 0, in_sum_cur, tv = 0, fin = 0, bp_done = 0, ab_now = 0, ab_done = 0;
        n_beat = 0; n_sum = 0; n_cum = 0; n_ld = 0; n_pd = 0; last_cum = -10; pd_cyc = -100;
        i_start_ok = 1'b1; done_i = 1'b1;
        for (int c = 0; c < 400 && !fin; c++) begin
            in_sum_cur = in_sum;
            in_valid = (tog && in_sum) ? tv : 1'b1;
            if (in_sum) tv = ~tv;
            out_ready = bp_left == 0;
            abort = ab_now;
            @(negedge clk);
            if (start_en && !hold) done_i = 1'b0;
            if (tog && in_sum_cur) begin
                total++;
                if (sum_en !== in_valid) begin bad++; $display("FAIL %s sum_valid got=%b exp=%b", nm, sum_en, in_valid); end
            end
            if (ld_en) begin
                if (n_ld > 0) begin
                    total++;
                    if (sum_row != 2 || cum_row != 9) begin
                        bad++; $display("FAIL %s row_counts got=%0d/%0d exp=2/9", nm, sum_row, cum_row);
                    end
                    if (!tog && !bp) begin
                        total++;
                        if (c - last_ld != 12) begin bad++; $display("FAIL %s row_len got=%0d exp=12", nm, c - last_ld); end
                    end
                end
                n_ld++; sum_row = 0; cum_row = 0; px_row = 0; last_ld = c; in_sum = tog; tv = 0;
            end
            if (count_en) px_row++;
            if (sum_en) begin
                n_sum++; sum_row++;
                if (sum_row == WIN - 1) in_sum = 0;
            end
            if (done_o && out_ready) begin
                if (cum_row == 0) begin
                    total++;
                    if (px_row != WIN) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, px_row, WIN); end
                end
                n_beat++;
            end
            if (cum_en) begin n_cum++; cum_row++; last_cum = c; end
            if (bp_left > 0) begin
                total++;
                if ({cum_en, count_en, in_ready, done_o, col_o} !== {1'b0, 1'b0, 1'b0, 1'b1, 4'd5}) begin
                    bad++;
                    $display("FAIL %s stall got=%b%b%b%b col=%0d exp=0001 col=5", nm, cum_en, count_en, in_ready, done_o, col_o);
                end
                bp_left--;
            end else if (bp && !bp_done && cum_en && row_o == 2'd0 && col_o == 4'd4) begin
                bp_left = 5; bp_done = 1;
            end
            if (ab_now) begin
                ab_now = 0; ab_done = 1; fin = 1;
            end else if (ab && !ab_done && count_en && row_o == 2'd2 && col_o == 4'd5) begin
                ab_now = 1;
            end
            if (progress_done) begin
                n_pd++; pd_cyc = c; fin = 1;
                total++;
                if (sum_row != 2 || cum_row != 9) begin
                    bad++; $display("FAIL %s last_row got=%0d/%0d exp=2/9", nm, sum_row, cum_row);
                end
            end
            tick();
        end
        abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        total++;
        if (!fin) begin bad++; $display("FAIL %s timeout got=running exp=finished", nm); end
        if (ab) begin
            done_i = 1'b0;
            @(negedge clk);
            total++;
            if (all_outs() !== 14'd0) begin bad++; $display("FAIL %s abort_idle got=%h exp=0", nm, all_outs()); end
            tick();
            repeat (3) begin
                @(negedge clk);
                if (progress_done) n_pd++;
                if (start_en) starts++;
                tick();
            end
            total++;
            if (n_pd != 0 || starts != 0) begin bad++; $display("FAIL %s abort_quiet got=pd%0d/st%0d exp=0/0", nm, n_pd, starts); end
        end else begin
            total++;
            if (n_beat != 36 || n_cum != 36) begin bad++; $display("FAIL %s beats got=%0d/%0d exp=36/36", nm, n_beat, n_cum); end
            total++;
            if (n_sum != 8 || n_ld != 4) begin bad++; $display("FAIL %s sum_ld got=%0d/%0d exp=8/4", nm, n_sum, n_ld); end
            total++;
            if (n_pd != 1 || pd_cyc - last_cum != 1) begin
                bad++; $display("FAIL %s progress got=n%0d gap%0d exp=n1 gap1", nm, n_pd, pd_cyc - last_cum);
            end
            if (hold) begin
                repeat (4) begin
                    @(negedge clk);
                    if (start_en || progress_done) starts++;
                    tick();
                end
                total++;
                if (starts != 0) begin bad++; $display("FAIL %s hold_done got=%0d exp=0", nm, starts); end
            end
        end
        done_i = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        run_frame("full", 0, 0, 0, 0);
    endtask

    task automatic test_back_pressure();
        run_frame("backpressure", 0, 1, 0, 0);
    endtask

    task automatic test_valid_toggle();
        run_frame("toggle", 1, 0, 0, 0);
    endtask

    task automatic test_abort();
        run_frame("abort", 0, 0, 1, 0);
        run_frame("after_abort", 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_frame("rearm_hold", 0, 0, 0, 1);
        run_frame("rearm_second", 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_pressure();
        test_valid_toggle();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
